// File: rtl/rv_pkg.sv
// RV32I opcode constants and decode helpers.
// Shared by the decode stage and the ALU.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic [4:0] rs1_idx(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_idx(input logic [31:0] inst);
    return inst[24:20];
  endfunction

  function automatic logic [4:0] rd_idx(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_JALR);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

  // Writes to x0 never count as producing a result.
  function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
    return (rd != 5'd0) &&
           ((opc == OPC_OP) || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
            (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
            (opc == OPC_JALR));
  endfunction

endpackage

// File: rtl/regfile.sv
// 32-entry integer register file, two read ports and one write port.
// x0 is hardwired to zero; BYPASS forwards same-cycle write data to the reads.
module regfile #(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs_q [32];

  // NOTE: the array is reset on purpose: software relies on every register reading zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rdata1 = regs_q[raddr1];
    rdata2 = regs_q[raddr2];
    if ((BYPASS != 0) && we && (waddr == raddr1)) rdata1 = wdata;
    if ((BYPASS != 0) && we && (waddr == raddr2)) rdata2 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/id_stage.sv
// Decode / operand-fetch stage: reads sources, stalls RAW hazards via a busy-bit
// scoreboard, and hands a registered inst/rs1/rs2 bundle to the ALU.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2;
  logic [31:0]     busy_q, busy_d, busy_eff, wb_mask;
  logic            hazard, accept;

  logic            out_valid_q;
  logic [31:0]     out_inst_q;
  logic [XLEN-1:0] out_rs1_q, out_rs2_q;

  assign opc = in_inst[6:0];
  assign rs1 = rs1_idx(in_inst);
  assign rs2 = rs2_idx(in_inst);
  assign rd  = rd_idx(in_inst);

  regfile #(.XLEN(XLEN), .BYPASS(BYPASS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  // With bypass, a register being written back this cycle no longer blocks a reader.
  always_comb begin
    wb_mask = '0;
    if (wb_en) wb_mask[wb_addr] = 1'b1;
    busy_eff = (BYPASS != 0) ? (busy_q & ~wb_mask) : busy_q;
    hazard   = (uses_rs1(opc) && (rs1 != 5'd0) && busy_eff[rs1]) ||
               (uses_rs2(opc) && (rs2 != 5'd0) && busy_eff[rs2]);
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // A new producer's set overrides the writeback clear of the same index.
  always_comb begin
    busy_d = busy_q & ~wb_mask;
    if (accept && writes_rd(opc, rd)) busy_d[rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
    end else begin
      busy_q <= busy_d;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_inst_q  <= in_inst;
        out_rs1_q   <= rdata1;
        out_rs2_q   <= rdata2;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_rs1   = out_rs1_q;
  assign out_rs2   = out_rs2_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage: one BYPASS=1 instance for the main
// sequence and one BYPASS=0 instance for the non-forwarding stall timing.
module tb_id_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, out_valid, out_ready, wb_en;
  logic [31:0] in_inst, out_inst, out_rs1, out_rs2, wb_data;
  logic [4:0]  wb_addr;

  logic        nb_rst, nb_in_valid, nb_in_ready, nb_out_valid, nb_out_ready, nb_wb_en;
  logic [31:0] nb_in_inst, nb_out_inst, nb_out_rs1, nb_out_rs2, nb_wb_data;
  logic [4:0]  nb_wb_addr;

  int tests = 0;
  int fails = 0;

  id_stage #(.XLEN(32), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  id_stage #(.XLEN(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(nb_rst), .in_valid(nb_in_valid), .in_ready(nb_in_ready), .in_inst(nb_in_inst),
    .out_valid(nb_out_valid), .out_ready(nb_out_ready), .out_inst(nb_out_inst),
    .out_rs1(nb_out_rs1), .out_rs2(nb_out_rs2),
    .wb_en(nb_wb_en), .wb_addr(nb_wb_addr), .wb_data(nb_wb_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    nb_rst = 1'b1; nb_in_valid = 1'b0; nb_in_inst = '0; nb_out_ready = 1'b1;
    nb_wb_en = 1'b0; nb_wb_addr = '0; nb_wb_data = '0;

    // Reset, with a writeback asserted that must be ignored.
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hFFFF_FFFF;
    step(); step();
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_rs1", out_rs1, 32'd0);
    check("rst_rs2", out_rs2, 32'd0);
    rst = 1'b0;

    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hCAFE_BABE; step();
    wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF; step();
    wb_en = 1'b0;

    // add x3,x1,x2
    in_valid = 1'b1; in_inst = 32'h0020_81B3; settle();
    check("add3_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("add3_valid", {31'b0, out_valid}, 32'd1);
    check("add3_inst", out_inst, 32'h0020_81B3);
    check("add3_rs1", out_rs1, 32'hCAFE_BABE);
    check("add3_rs2", out_rs2, 32'hDEAD_BEEF);

    // add x4,x3,x1 stalls on busy x3
    in_inst = 32'h0011_8233; settle();
    check("raw_stall", {31'b0, in_ready}, 32'd0);
    step();
    check("raw_drain_valid", {31'b0, out_valid}, 32'd0);
    check("raw_drain_hold", out_inst, 32'h0020_81B3);
    check("raw_stall2", {31'b0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hA9AC_79AD; settle();
    check("raw_bypass_ready", {31'b0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("add4_valid", {31'b0, out_valid}, 32'd1);
    check("add4_inst", out_inst, 32'h0011_8233);
    check("add4_rs1", out_rs1, 32'hA9AC_79AD);
    check("add4_rs2", out_rs2, 32'hCAFE_BABE);

    // Backpressure: add x6,x1,x2 waits while the ALU holds off
    in_inst = 32'h0020_8333; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_ready", {31'b0, in_ready}, 32'd0);
      step();
      check("bp_valid", {31'b0, out_valid}, 32'd1);
      check("bp_inst", out_inst, 32'h0011_8233);
      check("bp_rs1", out_rs1, 32'hA9AC_79AD);
      check("bp_rs2", out_rs2, 32'hCAFE_BABE);
    end
    out_ready = 1'b1; settle();
    check("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("add6_valid", {31'b0, out_valid}, 32'd1);
    check("add6_inst", out_inst, 32'h0020_8333);
    check("add6_rs1", out_rs1, 32'hCAFE_BABE);
    check("add6_rs2", out_rs2, 32'hDEAD_BEEF);

    // x0: write dropped, reads zero, never busy
    in_valid = 1'b0; wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234; step();
    wb_en = 1'b0;
    check("bubble_valid", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b1; in_inst = 32'h0000_02B3; settle();
    check("x0_ready", {31'b0, in_ready}, 32'd1);
    step();
    check("x0_rs1", out_rs1, 32'd0);
    check("x0_rs2", out_rs2, 32'd0);
    in_inst = 32'h0010_8033; step();
    in_inst = 32'h0000_03B3; settle();
    check("x0_no_hazard", {31'b0, in_ready}, 32'd1);
    step();
    check("add7_inst", out_inst, 32'h0000_03B3);

    // Set/clear race on x3
    in_inst = 32'h0020_81B3; step();
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0055; settle();
    check("race_ready", {31'b0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    in_inst = 32'h0001_8433; settle();
    check("race_busy_kept", {31'b0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h0000_0077; settle();
    check("race_release", {31'b0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("add8_inst", out_inst, 32'h0001_8433);
    check("add8_rs1", out_rs1, 32'h0000_0077);

    // Reset mid-stream with a valid bundle held
    out_ready = 1'b0; in_valid = 1'b0; rst = 1'b1; step();
    rst = 1'b0;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_inst", out_inst, 32'd0);
    check("mid_rst_rs1", out_rs1, 32'd0);
    check("mid_rst_rs2", out_rs2, 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h0012_04B3; settle();
    check("mid_rst_busy_clear", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("mid_rst_x1", out_rs2, 32'd0);
    check("mid_rst_valid2", {31'b0, out_valid}, 32'd1);

    // BYPASS=0: reader is accepted one cycle after the writeback
    step();
    nb_rst = 1'b0;
    nb_wb_en = 1'b1; nb_wb_addr = 5'd1; nb_wb_data = 32'h0000_0011; step();
    nb_wb_en = 1'b0;
    nb_in_valid = 1'b1; nb_in_inst = 32'h0020_81B3; step();
    check("nb_add3_rs1", nb_out_rs1, 32'h0000_0011);
    nb_in_inst = 32'h0011_8233; settle();
    check("nb_stall", {31'b0, nb_in_ready}, 32'd0);
    nb_wb_en = 1'b1; nb_wb_addr = 5'd3; nb_wb_data = 32'hA9AC_79AD; settle();
    check("nb_stall_wb", {31'b0, nb_in_ready}, 32'd0);
    step();
    nb_wb_en = 1'b0;
    check("nb_bubble", {31'b0, nb_out_valid}, 32'd0);
    check("nb_ready_after", {31'b0, nb_in_ready}, 32'd1);
    step();
    nb_in_valid = 1'b0;
    check("nb_add4_valid", {31'b0, nb_out_valid}, 32'd1);
    check("nb_add4_rs1", nb_out_rs1, 32'hA9AC_79AD);
    check("nb_add4_rs2", nb_out_rs2, 32'h0000_0011);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode/operand-fetch stage directly upstream of `alu`.
- Accepts 32-bit RV32I instructions from fetch and reads the 32x32 integer register file, with write-through bypass from writeback.
- Tracks in-flight destination registers in a busy-bit scoreboard and stalls read-after-write hazards.
- Presents a registered `inst`/`rs1`/`rs2` triple to `alu` under a valid/ready handshake.

Parameters:
- XLEN, 32, data width of registers and operand outputs.
- BYPASS, 1, 1 = same-cycle writeback data forwards to reads and clears busy before the hazard check; 0 = no forwarding; the reader waits one extra cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- in_inst  in  32  instruction word.
- out_valid  out  1  operand bundle valid to `alu`.
- out_ready  in  1  `alu` consumes the bundle.
- out_inst  out  32  registered instruction, to `alu.inst`.
- out_rs1  out  XLEN  registered rs1 value, to `alu.rs1`.
- out_rs2  out  XLEN  registered rs2 value, to `alu.rs2`.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback register index.
- wb_data  in  XLEN  writeback value.

Behaviour:
- Reset (`rst` high at a clk edge):
  - `out_valid`=0, `out_inst`=0, `out_rs1`=0, `out_rs2`=0.
  - All 32 registers = 0; all busy bits = 0.
  - `wb_en` is ignored during reset.
  - Reset mid-operation discards the held bundle with no handshake.
- Source decode, combinational on `in_inst[6:0]`:
  - uses_rs1 for OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - uses_rs2 for OP, STORE, BRANCH.
  - writes_rd for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd != 0.
  - Unknown opcode: no sources, no rd.
- Hazard: true if a used, nonzero source index has its busy bit set.
  - With BYPASS=1, a busy bit whose register matches `wb_addr` with `wb_en`=1 in the same cycle counts as clear.
- Handshake:
  - `in_ready` = (!`out_valid` || `out_ready`) && !hazard, computed combinationally.
  - `in_ready` does not depend on `in_valid`.
  - Accept = `in_valid` && `in_ready`.
- On accept, at the next edge:
  - `out_inst` <= `in_inst`.
  - `out_rs1`/`out_rs2` <= values read at index `in_inst[19:15]` / `in_inst[24:20]`.
  - `out_valid` <= 1.
- Output bundle:
  - Consumed when `out_valid` && `out_ready` with no accept: `out_valid` <= 0; data outputs hold their values.
  - While `out_valid`=1 and `out_ready`=0: all outputs hold stable.
- Latency: 1 cycle from accept to `out_valid`. Throughput: 1 per cycle when hazard-free.
- Register read:
  - Index 0 always reads 0.
  - BYPASS=1 and `wb_en` && `wb_addr`==index && index!=0 → `wb_data`; otherwise array contents.
  - Sources are read even when unused; the values are don't-care to `alu`.
- Write: `wb_en` && `wb_addr`!=0 → `regs[wb_addr]` <= `wb_data`. Writes to x0 are dropped.
- Scoreboard:
  - Accept with writes_rd sets `busy[rd]`.
  - `wb_en` clears `busy[wb_addr]`.
  - Set and clear of the same index in the same cycle → set wins (newer producer).
  - `busy[0]` is never set.
- Writeback to a non-busy register is legal: the data is written and busy is unchanged.

Decomposition:
- Shared package `rv_pkg`:
  - opcode localparams: OP=0110011, OP_IMM=0010011, LOAD=0000011, STORE=0100011, BRANCH=1100011, JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111.
  - field-slice functions: rs1_idx, rs2_idx, rd_idx.
  - uses_rs1 / uses_rs2 / writes_rd functions, shared with `alu` decode.
- One natural sub-module: `regfile` (2R1W, x0 hardwired, BYPASS parameter). The scoreboard and handshake stay in `id_stage`.

Test Plan:
- Reset, then write x1=0xCAFEBABE and x2=0xDEADBEEF via wb; feed 0x002081B3 (add x3,x1,x2) with `out_ready`=1 → next cycle `out_valid`=1, `out_inst`=0x002081B3, `out_rs1`=0xCAFEBABE, `out_rs2`=0xDEADBEEF; `busy[3]`=1.
- Follow immediately with 0x00118233 (add x4,x3,x1) → `in_ready`=0 until wb_en/x3/0xA9AC79AD. BYPASS=1: accepted in the wb cycle, `out_rs1`=0xA9AC79AD, `out_rs2`=0xCAFEBABE. BYPASS=0: accepted one cycle later with the same values.
- Backpressure: hold `out_ready`=0 with `out_valid`=1 for 3 cycles while `in_valid`=1 → `in_ready`=0 and outputs stable. Raise `out_ready` → a new bundle loads the same cycle with no bubble.
- x0: wb_en/x0/0x1234, then 0x000002B3 (add x5,x0,x0) → `out_rs1`=`out_rs2`=0; no hazard ever on x0.
- Set/clear race: with `busy[3]`=1, in the same cycle accept an instruction writing x3 and assert wb_en/x3 → `busy[3]` remains 1.
- Reset mid-stream with `out_valid`=1 → next cycle `out_valid`=0, outputs 0, busy all clear, x1 reads 0.
